regfile_wb_arbiter: RTL

//  Shares the register file's single write port among NREQ writeback requesters (ALU, load unit, PC/LR update).

---
 rtl/regfile_pkg.sv | 14 +
 rtl/rr_priority_picker.sv | 32 +++
 rtl/regfile_wb_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file widths and writeback arbiter state type
package regfile_pkg;

  localparam int RF_ADDR = 4;
  localparam int RF_SIZE = 32;
  localparam int RF_NUM  = 16;

  // ARB: round-robin among all requesters; LOCKED: one owner holds the write port for a burst
  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } wb_arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin picker: first set request at or after ptr
module rr_priority_picker #(
  parameter int NREQ = 3,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);

  logic [IW:0] cand;

  // Scan offsets from the far end back to ptr so the nearest requester after ptr wins last
  always_comb begin
    gnt  = '0;
    idx  = '0;
    cand = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (IW + 1)'(k);
      if (cand >= (IW + 1)'(NREQ)) begin
        cand = cand - (IW + 1)'(NREQ);
      end
      if (req[cand[IW-1:0]]) begin
        gnt                = '0;
        gnt[cand[IW-1:0]]  = 1'b1;
        idx                = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin writeback arbiter with burst lock for the register file write port
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ     = 3,
  parameter int ADDR     = RF_ADDR,
  parameter int SIZE     = RF_SIZE,
  parameter int LOCK_MAX = 16,
  parameter int IW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 Rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_lock,
  input  logic [NREQ*ADDR-1:0] req_addr,
  input  logic [NREQ*SIZE-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 Write_Reg,
  output logic [ADDR-1:0]      W_Addr,
  output logic [SIZE-1:0]      W_Data,
  output logic [IW-1:0]        grant_id,
  output logic [(1<<ADDR)-1:0] busy_mask
);

  // lock_cnt counts beats the owner has already taken in the current burst
  localparam int LCW      = $clog2(LOCK_MAX + 1);
  localparam bit CAN_LOCK = (LOCK_MAX > 1);

  wb_arb_state_t   state;
  wb_arb_state_t   state_nxt;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   win;
  logic [IW-1:0]   rr_nxt;
  logic [NREQ-1:0] pick_gnt;
  logic [LCW-1:0]  lock_cnt;
  logic            xfer;
  logic            win_lock;
  logic            lock_last;
  logic [ADDR-1:0] sel_addr;
  logic [SIZE-1:0] sel_data;

  rr_priority_picker #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_picker (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  assign win       = (state == LOCKED) ? owner : pick_idx;
  assign xfer      = |(req_ready & req_valid);
  assign win_lock  = req_lock[win];
  // The beat taken while lock_cnt == LOCK_MAX-1 is the owner's last one
  assign lock_last = (lock_cnt == LCW'(LOCK_MAX - 1));
  assign rr_nxt    = (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;

  // Select the winning requester's address and data fields
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IW'(i)) begin
        sel_addr = req_addr[i*ADDR +: ADDR];
        sel_data = req_data[i*SIZE +: SIZE];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state <= ARB;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: enter LOCKED on a locking beat, leave on an unlocked or final beat
  always_comb begin
    state_nxt = state;
    case (state)
      ARB: begin
        if (xfer && win_lock && CAN_LOCK) begin
          state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (xfer && (!win_lock || lock_last)) begin
          state_nxt = ARB;
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  // FSM outputs: ready to the round-robin winner, or only to the lock owner
  always_comb begin
    req_ready = '0;
    if (!Rst) begin
      case (state)
        ARB:     req_ready = pick_gnt;
        LOCKED:  req_ready[owner] = req_valid[owner];
        default: req_ready = '0;
      endcase
    end
  end

  // Round-robin pointer, lock owner and burst beat counter
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      rr_ptr   <= '0;
      owner    <= '0;
      lock_cnt <= '0;
    end else if (xfer) begin
      rr_ptr <= rr_nxt;
      if (state == ARB) begin
        owner    <= win;
        lock_cnt <= (win_lock && CAN_LOCK) ? LCW'(1) : '0;
      end else if (state_nxt == ARB) begin
        lock_cnt <= '0;
      end else begin
        lock_cnt <= lock_cnt + 1'b1;
      end
    end
  end

  // Registered write port: one cycle after acceptance, fields hold when idle
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      Write_Reg <= 1'b0;
      W_Addr    <= '0;
      W_Data    <= '0;
      grant_id  <= '0;
    end else begin
      Write_Reg <= xfer;
      if (xfer) begin
        W_Addr   <= sel_addr;
        W_Data   <= sel_data;
        grant_id <= win;
      end
    end
  end

  // Registers with a pending request or a write on the port this cycle
  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i]) begin
        busy_mask[req_addr[i*ADDR +: ADDR]] = 1'b1;
      end
    end
    if (Write_Reg) begin
      busy_mask[W_Addr] = 1'b1;
    end
  end

endmodule
